mod_inv: RTL and testbench
==========================

MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, bit width of the operand, modulus and result.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: A  input  WIDTH  operand to invert, unsigned.
REQ-005 SHALL have port: B  output  WIDTH  registered result, the inverse of A mod p.
REQ-006 SHALL have port: p  input  WIDTH  modulus, unsigned, odd and at least 3.
REQ-007 SHALL have port: start  input  1  level-sampled request to begin a computation.
REQ-008 SHALL have port: busy  output  1  registered; high while a computation is in progress.
REQ-009 SHALL have port: err  output  1  registered; high when the last computation was invalid.

Function
REQ-010 SHALL use the states IDLE and CALC.
REQ-011 SHALL, in IDLE with start=1 at a rising edge, capture A and p in that same edge.
REQ-012 SHALL, on that capture edge, load u=A, v=p, x1=1, x2=0, clear err, set busy=1 and go to CALC; busy is therefore high at the first edge after start is driven.
REQ-013 SHALL ignore start while in CALC.
REQ-014 SHALL treat A and p changes during CALC as having no effect on the result.
REQ-015 SHALL, in CALC with u==1, set B=x1, busy=0 and go to IDLE.
REQ-016 SHALL, in CALC with u!=1 and v==1, set B=x2, busy=0 and go to IDLE.
REQ-017 SHALL, otherwise, perform exactly one step of binary inversion per cycle, in the priority order of REQ-018 to REQ-021.
REQ-018 SHALL, when u is even, set u=u>>1 and halve x1 mod p (x1 odd: (x1+p)>>1 with a WIDTH+1-bit sum).
REQ-019 SHALL, else when v is even, apply the same rule as REQ-018 to v and x2.
REQ-020 SHALL, else when u>=v, set u=u-v and x1=(x1-x2) mod p, adding p on borrow.
REQ-021 SHALL, else, set v=v-u and x2=(x2-x1) mod p.
REQ-022 SHALL keep x1 and x2 in [0,p-1] at all times.
REQ-023 SHALL use an iteration counter that forces termination after 4*WIDTH CALC cycles, with busy=0, B=0 and return to IDLE.
REQ-024 SHALL hold B and err stable in IDLE until the next completion.
REQ-025 SHALL, when start is still high at the completion edge, restart on the following edge.
REQ-026 SHALL produce B with A*B mod p == 1 for any valid input (1<=A<p, gcd(A,p)=1, p odd).
REQ-027 SHALL, for A=1, keep busy high for exactly one cycle and produce B=1.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force the state to IDLE and set busy=0, B=0, err=0, u=0, v=0, x1=0, x2=0 and the counter to 0.
REQ-029 SHALL, on reset asserted mid-computation, abort the computation with no result update.
REQ-030 SHALL, after reset release, wait for a new start.

Configuration
REQ-031 SHALL, with macro MOD_INV_ERR_CHECK_EN defined, detect on capture: A==0, A>=p, p even, or p<3.
REQ-032 SHALL, on such a capture-time condition, finish at the next edge with err=1, B=0, busy=0 and no CALC iterations.
REQ-033 SHALL, with MOD_INV_ERR_CHECK_EN defined, finish any CALC cycle with u==0 or v==0 (gcd not 1) with err=1, B=0, busy=0.
REQ-034 SHALL, with MOD_INV_ERR_CHECK_EN defined, set err=1 on a timeout.
REQ-035 SHALL, without MOD_INV_ERR_CHECK_EN, tie err to constant 0 and omit the capture checks.
REQ-036 SHALL, without MOD_INV_ERR_CHECK_EN, leave B unspecified for invalid inputs while still terminating via REQ-023.

Verification
REQ-037 SHALL cover: p=13, A=1..12 in sequence, each start pulsed then busy awaited -> B equals 1,7,9,10,8,11,2,5,3,4,6,12 and A*B mod 13 == 1.
REQ-038 SHALL cover: p=13, A=1 -> busy high exactly one cycle, B=1.
REQ-039 SHALL cover: p=13, A=5, start held high through completion -> B=8, then busy re-asserts on the next edge with the same result.
REQ-040 SHALL cover: p=13, A=7, rst_n pulsed low two cycles after start -> busy=0 and B=0 immediately, then A=7 restarted -> B=2.
REQ-041 SHALL cover: MOD_INV_ERR_CHECK_EN defined; A=0, p=13 -> err=1, B=0 after one busy cycle; A=3, p=9 -> err=1, B=0; then A=4, p=9 -> err=0, B=7.
REQ-042 SHALL cover: WIDTH=8, p=251, A=2 -> B=126, with busy low within 32 cycles.

Source files
------------

// File: rtl/mod_inv.sv
// Modular inverse B = A^-1 mod p via binary extended Euclid, one step per cycle.
// Optional input/gcd checking and err reporting enabled by macro MOD_INV_ERR_CHECK_EN.
module mod_inv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] p,
  input  logic             start,
  output logic             busy,
  output logic             err
);

  localparam int MAX_ITER = 4 * WIDTH;
  localparam int CW       = $clog2(MAX_ITER + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2, r_p;
  logic [CW-1:0]    r_cnt;

  // x/2 mod m for odd m: an odd x is made even by adding m first.
  // NOTE: the sum is WIDTH+1 bits wide so the carry out of x+m survives the shift.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // (a-b) mod m for a,b in [0,m-1]; a borrow is repaired by adding m back.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

`ifdef MOD_INV_ERR_CHECK_EN
  logic r_err;
  logic r_bad;
  logic w_bad_in;
  assign w_bad_in = (A == '0) || (A >= p) || !p[0] || (p < WIDTH'(3));
  assign err      = r_err;
`else
  assign err = 1'b0;
`endif

  // NOTE: every state/datapath register is cleared by the async reset, so an
  // aborted computation leaves no partial result visible on B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      B       <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
`ifdef MOD_INV_ERR_CHECK_EN
      r_err   <= 1'b0;
      r_bad   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_u     <= A;
            r_v     <= p;
            r_p     <= p;
            r_x1    <= WIDTH'(1);
            r_x2    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= CALC;
`ifdef MOD_INV_ERR_CHECK_EN
            r_err   <= 1'b0;
            r_bad   <= w_bad_in;
`endif
          end
        end

        CALC: begin
`ifdef MOD_INV_ERR_CHECK_EN
          // Invalid operands, or a zero residue meaning gcd(A,p) != 1.
          if (r_bad || r_u == '0 || r_v == '0) begin
            B       <= '0;
            busy    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else
`endif
          if (r_u == WIDTH'(1)) begin
            B       <= r_x1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_v == WIDTH'(1)) begin
            B       <= r_x2;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == CW'(MAX_ITER)) begin
            B       <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
`ifdef MOD_INV_ERR_CHECK_EN
            r_err   <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_u[0]) begin
              r_u  <= r_u >> 1;
              r_x1 <= half_mod(r_x1, r_p);
            end else if (!r_v[0]) begin
              r_v  <= r_v >> 1;
              r_x2 <= half_mod(r_x2, r_p);
            end else if (r_u >= r_v) begin
              r_u  <= r_u - r_v;
              r_x1 <= sub_mod(r_x1, r_x2, r_p);
            end else begin
              r_v  <= r_v - r_u;
              r_x2 <= sub_mod(r_x2, r_x1, r_p);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: directed scenarios plus randomized operands
// checked against a brute-force modular inverse model.
module tb_mod_inv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a4, p4, b4;
  logic       start4, busy4, err4;
  logic [7:0] a8, p8, b8;
  logic       start8, busy8, err8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_inv #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .p(p4),
    .start(start4), .busy(busy4), .err(err4)
  );

  mod_inv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .p(p8),
    .start(start8), .busy(busy8), .err(err8)
  );

  // Reference: the unique b in [1,m-1] with a*b = 1 (mod m), 0 if none exists.
  function automatic int inv_ref(input int a, input int m);
    for (int b = 1; b < m; b++)
      if ((a * b) % m == 1) return b;
    return 0;
  endfunction

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Pulse (or hold) start and count cycles with busy high, bounded.
  task automatic op4(input int a, input int m, input bit hold, output int cyc);
    bit done;
    @(negedge clk);
    a4 = 4'(a); p4 = 4'(m); start4 = 1'b1;
    @(negedge clk);
    if (!hold) start4 = 1'b0;
    cyc = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy4) done = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL op4_timeout: A=%0d p=%0d busy still %b, want 0", a, m, busy4);
    end
  endtask

  task automatic op8(input int a, input int m, output int cyc);
    bit done;
    @(negedge clk);
    a8 = 8'(a); p8 = 8'(m); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!busy8) done = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL op8_timeout: A=%0d p=%0d busy still %b, want 0", a, m, busy8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; p4 = 4'd13;
    start8 = 1'b0; a8 = '0; p8 = 8'd251;
    #12;
    n_checks++;
    if ({b4, busy4, err4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_w4: B=%0d busy=%b err=%b, want 0 0 0", b4, busy4, err4);
    end
    n_checks++;
    if ({b8, busy8, err8} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_w8: B=%0d busy=%b err=%b, want 0 0 0", b8, busy8, err8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b, want 0", busy4);
    end
  endtask

  task automatic test_table();
    int tbl [12] = '{1, 7, 9, 10, 8, 11, 2, 5, 3, 4, 6, 12};
    int cyc;
    for (int i = 1; i <= 12; i++) begin
      op4(i, 13, 1'b0, cyc);
      n_checks++;
      if (int'(b4) !== tbl[i-1]) begin
        n_fail++;
        $display("FAIL table: A=%0d B=%0d, want %0d", i, b4, tbl[i-1]);
      end
      n_checks++;
      if ((i * int'(b4)) % 13 != 1) begin
        n_fail++;
        $display("FAIL table_prod: A=%0d B=%0d product mod 13 = %0d, want 1",
                 i, b4, (i * int'(b4)) % 13);
      end
    end
  endtask

  task automatic test_a_one();
    int cyc;
    op4(1, 13, 1'b0, cyc);
    n_checks++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL a_one_busy: busy cycles=%0d, want 1", cyc);
    end
    n_checks++;
    if (b4 !== 4'd1) begin
      n_fail++;
      $display("FAIL a_one_b: B=%0d, want 1", b4);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    bit  done;
    op4(5, 13, 1'b1, cyc);
    n_checks++;
    if (b4 !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_first: B=%0d, want 8", b4);
    end
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b1 || b4 !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_restart: busy=%b B=%0d, want 1 8", busy4, b4);
    end
    start4 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy4) done = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!done || b4 !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_second: done=%b B=%0d, want 1 8", done, b4);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    @(negedge clk);
    a4 = 4'd7; p4 = 4'd13; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || b4 !== 4'd0) begin
      n_fail++;
      $display("FAIL abort: busy=%b B=%0d, want 0 0", busy4, b4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait: busy=%b, want 0", busy4);
    end
    op4(7, 13, 1'b0, cyc);
    n_checks++;
    if (b4 !== 4'd2) begin
      n_fail++;
      $display("FAIL abort_restart: B=%0d, want 2", b4);
    end
  endtask

`ifdef MOD_INV_ERR_CHECK_EN
  task automatic test_err_check();
    int cyc;
    op4(0, 13, 1'b0, cyc);
    n_checks++;
    if (cyc != 1 || err4 !== 1'b1 || b4 !== 4'd0) begin
      n_fail++;
      $display("FAIL err_zero: cyc=%0d err=%b B=%0d, want 1 1 0", cyc, err4, b4);
    end
    op4(3, 9, 1'b0, cyc);
    n_checks++;
    if (err4 !== 1'b1 || b4 !== 4'd0) begin
      n_fail++;
      $display("FAIL err_gcd: err=%b B=%0d, want 1 0", err4, b4);
    end
    op4(4, 9, 1'b0, cyc);
    n_checks++;
    if (err4 !== 1'b0 || b4 !== 4'd7) begin
      n_fail++;
      $display("FAIL err_clear: err=%b B=%0d, want 0 7", err4, b4);
    end
  endtask
`endif

  task automatic test_wide();
    int cyc;
    op8(2, 251, cyc);
    n_checks++;
    if (b8 !== 8'd126) begin
      n_fail++;
      $display("FAIL wide_b: B=%0d, want 126", b8);
    end
    n_checks++;
    if (cyc > 32) begin
      n_fail++;
      $display("FAIL wide_latency: busy cycles=%0d, want <= 32", cyc);
    end
  endtask

  task automatic test_random();
    int cyc, m, a, exp;
    for (int n = 0; n < 30; n++) begin
      m = 2 * $urandom_range(1, 7) + 1;
      do a = $urandom_range(1, m - 1); while (gcd(a, m) != 1);
      exp = inv_ref(a, m);
      op4(a, m, 1'b0, cyc);
      n_checks++;
      if (int'(b4) !== exp || err4 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_w4: A=%0d p=%0d B=%0d err=%b, want %0d 0", a, m, b4, err4, exp);
      end
    end
    for (int n = 0; n < 20; n++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      do a = $urandom_range(1, m - 1); while (gcd(a, m) != 1);
      exp = inv_ref(a, m);
      op8(a, m, cyc);
      n_checks++;
      if (int'(b8) !== exp || err8 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_w8: A=%0d p=%0d B=%0d err=%b, want %0d 0", a, m, b8, err8, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_a_one();
    test_back_to_back();
    test_reset_abort();
`ifdef MOD_INV_ERR_CHECK_EN
    test_err_check();
`endif
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
